adder_operand_loader: RTL
=========================

# adder_operand_loader

Sequential front-end that feeds the 4-bit ripple adder one operand at a time from a shared data bus. It captures operand A, then operand B and carry-in, on successive rising edges of a `load` strobe. It presents the registered operands to the adder, samples the adder's sum and carry-out one cycle later, and holds the result with a valid flag until the next operation starts.

## Interface
- `WIDTH`, default 4: operand width; the result is `WIDTH+1` bits.
- `clk` input 1: system clock, rising-edge active.
- `reset` input 1: asynchronous, active-high; forces the reset state below.
- `clear` input 1: synchronous abort; returns to `S_IDLE`, zeroes all registers; priority over `load`.
- `load` input 1: level strobe (button-style), only its rising edge is used.
- `data_in` input WIDTH: operand bus, sampled on a detected `load` edge.
- `cin_in` input 1: carry-in, sampled together with operand B.
- `sum_in` input WIDTH+1: adder output {cout, s} returned from the adder.
- `a` output WIDTH: registered operand A to the adder.
- `b` output WIDTH: registered operand B to the adder.
- `cin` output 1: registered carry-in to the adder.
- `result` output WIDTH+1: captured {cout, s}.
- `result_valid` output 1: high while `result` holds a completed sum.
- `busy` output 1: high in `S_WAIT_B` and `S_ADD`.
- `state` output 2: current FSM state, for LED debug.

## Operation
- The edge detector registers `load` into `load_q`. `load_edge = load & ~load_q`. `load_q` resets to 0.
- FSM states and transitions:
  - `S_IDLE` (00): on `load_edge`, `a <= data_in`, go to `S_WAIT_B`.
  - `S_WAIT_B` (01): on `load_edge`, `b <= data_in` and `cin <= cin_in`, go to `S_ADD`.
  - `S_ADD` (10): unconditional, `result <= sum_in` and `result_valid <= 1`, go to `S_DONE`.
  - `S_DONE` (11): hold the result. On `load_edge`, `a <= data_in` and `result_valid <= 0`, go to `S_WAIT_B`. A new operation starts directly from `S_DONE`.
- A `load_edge` arriving in `S_ADD` is ignored and lost; it is not queued.
- `a`, `b` and `cin` hold their values between captures. The adder sees stable inputs throughout `S_ADD`.
- Arithmetic is done by the external adder only; this block does no addition. `result` is exactly WIDTH+1 bits with no truncation, so 15+15+1 gives 5'b11111.
- `clear`, in any state: all outputs return to their reset values on the next edge and `load_q` still updates. `clear` and `load_edge` in the same cycle means `clear` wins and the edge is discarded.
- Reset values: `a`=0, `b`=0, `cin`=0, `result`=0, `result_valid`=0, `busy`=0, `state`=`S_IDLE`.
- Reset asserted mid-operation takes effect immediately (asynchronous) and discards any partial operands.

## Timing
- The block captures on the same clock edge where `load_edge` is true, one cycle after `load` rises at the input.
- From the B-capture edge to `result_valid` high is exactly 1 cycle, via `S_ADD`.
- `result_valid` stays high until the `load_edge` that captures the next A. It falls on that clock edge.
- `busy` and `state` are registered decodes and change on the same edges as the state register.
- Holding `load` high produces a single edge only. A new edge requires `load` to go low for at least 1 cycle.
- The adder path `a`/`b`/`cin` → `sum_in` must settle within one clock period. `sum_in` is combinational from this block's registers.

## Structure
- Shared include `adder_seq_defs.vh` holds:
  - state encodings `S_IDLE`, `S_WAIT_B`, `S_ADD`, `S_DONE`
  - default `WIDTH`
- One sub-module, `rise_detect` (clk, reset, in, edge), which is reused elsewhere for KEY inputs.
- The top-level bench instantiates `adder_operand_loader` with the existing ripple adder in loopback: `a`, `b` and `cin` feed the adder, and the adder's {cout, s} returns on `sum_in`.

## Test plan
- **Basic add:** reset, then load edges with `data_in`=3, then `data_in`=5 with `cin_in`=0 → `result`=5'd8 and `result_valid`=1 exactly 1 cycle after the B capture; `busy` is 0 in `S_DONE`.
- **Max overflow:** A=15, B=15, `cin_in`=1 → `result`=5'b11111; A=8, B=8, `cin_in`=0 → `result`=5'b10000.
- **Held strobe:** `load` held high for 10 cycles in `S_IDLE` → only A is captured, `state`=01, and B is not captured until `load` drops and rises again.
- **Restart from DONE:** after result 8, a load edge with `data_in`=7 → `result_valid` falls on that edge, `a`=7, `state`=01, and `result` keeps the old value until the next `S_ADD`.
- **Clear/load collision:** in `S_WAIT_B`, assert `clear` in the same cycle as a load edge → `state`=00 and `a`=`b`=`result`=0 on the next edge, with no B capture.
- **Async reset mid-op:** assert `reset` between clock edges while in `S_ADD` → all outputs are at their reset values before the next clock edge, and the next operation runs normally.

Source files
------------

// File: rtl/adder_operand_loader_pkg.sv
// Shared definitions for the sequential operand loader: state encodings and default width.
package adder_operand_loader_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Loader FSM encoding; also driven out on the debug LED port.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT_B = 2'b01,
    S_ADD    = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  // States in which an operation is in flight.
  function automatic logic state_is_busy(input state_t s);
    return (s == S_WAIT_B) || (s == S_ADD);
  endfunction

endpackage

// File: rtl/adder_operand_loader_rise_detect.sv
// Rising-edge detector for a level strobe such as a push button.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic edge_c
);

  logic in_q;

  // Remember the previous level of the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_i;
    end
  end

  // One-cycle pulse on a low-to-high transition; a held level yields a single pulse.
  assign edge_c = in_i & ~in_q;

endmodule

// File: rtl/adder_operand_loader.sv
// Captures A, then B and carry-in, from a shared bus on load edges, and latches the
// external adder's {cout, s} one cycle after B is captured.
module adder_operand_loader
  import adder_operand_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cin_in,
  input  logic [WIDTH:0]   sum_in,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             busy,
  output logic [1:0]       state
);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [WIDTH:0]   result_q;
  logic             result_valid_q;
  logic             busy_q;
  logic             load_edge_c;

  // Edge detector keeps running through clear so a held strobe is not re-seen afterwards.
  rise_detect u_load_rise (
    .clk    (clk),
    .reset  (reset),
    .in_i   (load),
    .edge_c (load_edge_c)
  );

  // Loader FSM with its operand/result registers; clear outranks any load edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      cin_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else if (clear) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      cin_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_edge_c) begin
            a_q     <= data_in;
            state_q <= S_WAIT_B;
            busy_q  <= state_is_busy(S_WAIT_B);
          end
        end
        S_WAIT_B: begin
          if (load_edge_c) begin
            b_q     <= data_in;
            cin_q   <= cin_in;
            state_q <= S_ADD;
            busy_q  <= state_is_busy(S_ADD);
          end
        end
        S_ADD: begin
          // Operands have been stable for a full period; any load edge here is dropped.
          result_q       <= sum_in;
          result_valid_q <= 1'b1;
          state_q        <= S_DONE;
          busy_q         <= state_is_busy(S_DONE);
        end
        S_DONE: begin
          if (load_edge_c) begin
            a_q            <= data_in;
            result_valid_q <= 1'b0;
            state_q        <= S_WAIT_B;
            busy_q         <= state_is_busy(S_WAIT_B);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign cin          = cin_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule
